// File: rtl/projectile_launch_ctrl.sv
// Launch sequencer for a pool of projectile movers: fire-edge to one-hot load strobe,
// frame-based cooldown between shots, and per-slot in-flight tracking.

module projectile_slot (
    input  logic clk,
    input  logic resetN,
    input  logic i_load,
    input  logic i_end,
    output logic o_active
);
    logic r_active;

    // The load strobe wins over end-of-flight: the mover still reports its stale position then.
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN)     r_active <= 1'b0;
        else if (i_load) r_active <= 1'b1;
        else if (i_end)  r_active <= 1'b0;
    end

    assign o_active = r_active;
endmodule

module projectile_launch_ctrl #(
    parameter int NUM_SLOTS       = 4,
    parameter int COOLDOWN_FRAMES = 8,
    parameter int X_OFFSET        = 16
) (
    input  logic                  clk,
    input  logic                  resetN,
    input  logic                  startOfFrame,
    input  logic                  fireRequest,
    input  logic signed [10:0]    playerX,
    input  logic signed [10:0]    playerY,
    input  logic [NUM_SLOTS-1:0]  projectileEnd,
    output logic [NUM_SLOTS-1:0]  loadInitialCoordinates,
    output logic signed [10:0]    launchX,
    output logic signed [10:0]    launchY,
    output logic [NUM_SLOTS-1:0]  slotActive,
    output logic                  readyToFire,
    output logic                  fireDenied
);
    localparam int SLOT_W = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, COOLDOWN} state_t;

    state_t                r_state, w_next;
    logic                  r_fireReg;
    logic [SLOT_W-1:0]     r_slot;
    logic [7:0]            r_cnt;
    logic [NUM_SLOTS-1:0]  r_load;
    logic signed [10:0]    r_launchX, r_launchY;
    logic                  r_denied;

    logic                  w_fireEdge;
    logic                  w_hasFree;
    logic [SLOT_W-1:0]     w_freeIdx;
    logic                  w_latch;
    logic                  w_deny;
    logic                  w_cntDec;

    assign w_fireEdge = fireRequest & ~r_fireReg;

    // Lowest free slot, taken from the registered vector so a slot ending this cycle is not eligible.
    always_comb begin
        w_freeIdx = '0;
        w_hasFree = 1'b0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--) begin
            if (!slotActive[i]) begin
                w_freeIdx = SLOT_W'(i);
                w_hasFree = 1'b1;
            end
        end
    end

    always_comb begin
        w_next   = r_state;
        w_latch  = 1'b0;
        w_deny   = 1'b0;
        w_cntDec = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_fireEdge) begin
                    if (w_hasFree) begin
                        w_latch = 1'b1;
                        w_next  = LOAD;
                    end else begin
                        w_deny = 1'b1;
                    end
                end
            end
            LOAD: begin
                w_deny = w_fireEdge;
                w_next = COOLDOWN;
            end
            COOLDOWN: begin
                w_deny = w_fireEdge;
                if (startOfFrame) begin
                    w_cntDec = 1'b1;
                    if (r_cnt <= 8'd1) w_next = IDLE;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            r_state   <= IDLE;
            r_fireReg <= 1'b0;
            r_slot    <= '0;
            r_cnt     <= '0;
            r_load    <= '0;
            r_launchX <= '0;
            r_launchY <= '0;
            r_denied  <= 1'b0;
        end else begin
            r_state   <= w_next;
            r_fireReg <= fireRequest;
            r_denied  <= w_deny;
            r_load    <= (r_state == LOAD) ? (NUM_SLOTS'(1) << r_slot) : '0;
            if (w_latch) begin
                r_launchX <= playerX + 11'(X_OFFSET);
                r_launchY <= playerY;
                r_slot    <= w_freeIdx;
            end
            // A frame pulse during LOAD is dropped because the counter is reloaded here.
            if (r_state == LOAD)  r_cnt <= 8'(COOLDOWN_FRAMES);
            else if (w_cntDec)    r_cnt <= r_cnt - 8'd1;
        end
    end

    projectile_slot u_slot [NUM_SLOTS-1:0] (
        .clk      (clk),
        .resetN   (resetN),
        .i_load   (r_load),
        .i_end    (projectileEnd),
        .o_active (slotActive)
    );

    assign loadInitialCoordinates = r_load;
    assign launchX                = r_launchX;
    assign launchY                = r_launchY;
    assign fireDenied             = r_denied;
    assign readyToFire            = (r_state == IDLE) & ~&slotActive;
endmodule

// File: tb/tb_projectile_launch_ctrl.sv
// Scoreboard bench: stimulus queues expected strobe/deny events, a negedge monitor pops and compares.

module tb_projectile_launch_ctrl;
    logic              clk = 1'b0;
    logic              resetN = 1'b0;
    logic              startOfFrame = 1'b0;
    logic              fireRequest = 1'b0;
    logic signed [10:0] playerX = '0;
    logic signed [10:0] playerY = '0;
    logic [3:0]        projectileEnd = '0;
    logic [3:0]        loadInitialCoordinates;
    logic signed [10:0] launchX, launchY;
    logic [3:0]        slotActive;
    logic              readyToFire, fireDenied;

    typedef struct {
        logic [3:0]  load;
        logic        deny;
        logic [10:0] x;
        logic [10:0] y;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    projectile_launch_ctrl #(.NUM_SLOTS(4), .COOLDOWN_FRAMES(8), .X_OFFSET(16)) dut (
        .clk                    (clk),
        .resetN                 (resetN),
        .startOfFrame           (startOfFrame),
        .fireRequest            (fireRequest),
        .playerX                (playerX),
        .playerY                (playerY),
        .projectileEnd          (projectileEnd),
        .loadInitialCoordinates (loadInitialCoordinates),
        .launchX                (launchX),
        .launchY                (launchY),
        .slotActive             (slotActive),
        .readyToFire            (readyToFire),
        .fireDenied             (fireDenied)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, act=running req=finished");
        $fatal(1, "watchdog");
    end

    // Every strobe cycle and every deny pulse must match the head of the queue.
    always @(negedge clk) begin
        if (resetN && (loadInitialCoordinates != 4'b0 || fireDenied)) begin
            exp_t e;
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event act load=%b deny=%b req none", loadInitialCoordinates, fireDenied);
            end else begin
                e = q.pop_front();
                if (loadInitialCoordinates != e.load || fireDenied != e.deny ||
                    (e.load != 4'b0 && (launchX != e.x || launchY != e.y))) begin
                    bad++;
                    $display("FAIL event act load=%b deny=%b x=%0d y=%0d req load=%b deny=%b x=%0d y=%0d",
                             loadInitialCoordinates, fireDenied, launchX, launchY,
                             e.load, e.deny, $signed(e.x), $signed(e.y));
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s act=%0h req=%0h", name, act, req);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_launch(input logic [3:0] ld, input int x, input int y);
        exp_t e;
        e.load = ld; e.deny = 1'b0; e.x = 11'(x); e.y = 11'(y);
        q.push_back(e);
    endtask

    task automatic push_deny();
        exp_t e;
        e.load = 4'b0; e.deny = 1'b1; e.x = '0; e.y = '0;
        q.push_back(e);
    endtask

    task automatic fire();
        fireRequest = 1'b1;
        cyc(1);
        fireRequest = 1'b0;
        cyc(1);
    endtask

    task automatic sof(input int n);
        repeat (n) begin
            startOfFrame = 1'b1;
            cyc(1);
            startOfFrame = 1'b0;
            cyc(2);
        end
    endtask

    initial begin
        cyc(3);
        resetN = 1'b1;
        cyc(1);
        chk("rst_slotActive", 32'(slotActive), 32'h0);
        chk("rst_load", 32'(loadInitialCoordinates), 32'h0);
        chk("rst_launchX", 32'(launchX), 32'h0);
        chk("rst_launchY", 32'(launchY), 32'h0);
        chk("rst_fireDenied", 32'(fireDenied), 32'h0);
        chk("rst_readyToFire", 32'(readyToFire), 32'h1);

        // single shot
        playerX = 11'sd100; playerY = 11'sd400;
        push_launch(4'b0001, 116, 400);
        fire();
        cyc(2);
        chk("single_slotActive", 32'(slotActive), 32'h1);
        chk("single_ready_busy", 32'(readyToFire), 32'h0);
        sof(7);
        chk("single_ready_7frames", 32'(readyToFire), 32'h0);
        sof(1);
        chk("single_ready_8frames", 32'(readyToFire), 32'h1);

        // cooldown rejection, negative coordinates
        playerX = -11'sd50; playerY = -11'sd5;
        push_launch(4'b0010, -34, -5);
        fire();
        cyc(2);
        sof(3);
        push_deny();
        fire();
        cyc(2);
        chk("cool_slotActive", 32'(slotActive), 32'h3);
        sof(5);
        chk("cool_ready", 32'(readyToFire), 32'h1);

        // launch X wraps at 11 bits
        playerX = 11'sd1020; playerY = 11'sd0;
        push_launch(4'b0100, -1012, 0);
        fire();
        cyc(2);
        sof(8);
        chk("wrap_slotActive", 32'(slotActive), 32'h7);

        // simultaneous end of slot 0 and fire edge: slot 3 is taken
        playerX = 11'sd200; playerY = -11'sd300;
        push_launch(4'b1000, 216, -300);
        fireRequest = 1'b1; projectileEnd = 4'b0001;
        cyc(1);
        fireRequest = 1'b0; projectileEnd = 4'b0000;
        cyc(3);
        chk("simul_slotActive", 32'(slotActive), 32'hE);
        sof(8);

        // pool exhaustion
        push_launch(4'b0001, 216, -300);
        fire();
        cyc(2);
        sof(8);
        chk("full_slotActive", 32'(slotActive), 32'hF);
        chk("full_ready", 32'(readyToFire), 32'h0);
        push_deny();
        fire();
        cyc(2);
        chk("full_denied_slotActive", 32'(slotActive), 32'hF);
        projectileEnd = 4'b0100;
        cyc(1);
        projectileEnd = 4'b0000;
        chk("release2_slotActive", 32'(slotActive), 32'hB);
        chk("release2_ready", 32'(readyToFire), 32'h1);
        push_launch(4'b0100, 216, -300);
        fire();
        cyc(2);
        chk("refill_slotActive", 32'(slotActive), 32'hF);
        sof(8);

        // stale end held through the load of slot 0
        projectileEnd = 4'b0001;
        cyc(1);
        chk("free0_slotActive", 32'(slotActive), 32'hE);
        push_launch(4'b0001, 216, -300);
        fire();
        cyc(1);
        chk("stale_set_slotActive", 32'(slotActive), 32'hF);
        cyc(1);
        chk("stale_clear_slotActive", 32'(slotActive), 32'hE);
        projectileEnd = 4'b0000;

        // asynchronous reset in the middle of cooldown
        #2;
        resetN = 1'b0;
        #1;
        chk("arst_slotActive", 32'(slotActive), 32'h0);
        chk("arst_load", 32'(loadInitialCoordinates), 32'h0);
        chk("arst_launchX", 32'(launchX), 32'h0);
        chk("arst_launchY", 32'(launchY), 32'h0);
        chk("arst_fireDenied", 32'(fireDenied), 32'h0);
        cyc(2);
        resetN = 1'b1;
        cyc(1);
        chk("arst_ready", 32'(readyToFire), 32'h1);
        push_launch(4'b0001, 216, -300);
        fire();
        cyc(2);
        chk("post_rst_slotActive", 32'(slotActive), 32'h1);

        cyc(5);
        chk("pending_events", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/projectile_launch_ctrl.md
# projectile_launch_ctrl

Sequencer for a pool of projectile movers. It converts the player's fire button into one-cycle load pulses for the lowest-index free projectile slot and latches the launch coordinates. It enforces a frame-based cooldown between shots and frees slots when their mover reports end-of-flight. It sits between the player/keypad logic and an array of NUM_SLOTS projectile movers, which share its launch coordinate outputs.

## Interface
- NUM_SLOTS, 4: number of projectile movers managed (1..8).
- COOLDOWN_FRAMES, 8: frames that must elapse after a launch before the next launch (1..255).
- X_OFFSET, 16: signed pixel offset added to playerX to form launch X.
- clk  in  1  system clock.
- resetN  in  1  reset, asynchronous, active-low.
- startOfFrame  in  1  one-cycle pulse per video frame (30 Hz).
- fireRequest  in  1  fire button level; only its rising edge counts.
- playerX  in  11 signed  player top-left X.
- playerY  in  11 signed  player top-left Y.
- projectileEnd  in  NUM_SLOTS  per-slot end-of-flight flag from each mover (collision or off-screen).
- loadInitialCoordinates  out  NUM_SLOTS  one-hot, one-cycle load strobe to the chosen mover.
- launchX  out  11 signed  latched launch X, shared by all movers.
- launchY  out  11 signed  latched launch Y, shared by all movers.
- slotActive  out  NUM_SLOTS  slot i currently in flight (drives its drawer enable).
- readyToFire  out  1  high in IDLE when at least one slot is free.
- fireDenied  out  1  one-cycle pulse when a fire edge is rejected.

## Operation
- Edge detect: fireReg holds the previous fireRequest. fireEdge = fireRequest & ~fireReg.
- Free slot = lowest index i with slotActive[i]==0, evaluated on the registered slotActive at the start of the cycle.
- FSM states and transitions:
  - IDLE:
    - fireEdge with a free slot: latch launchX = playerX + X_OFFSET (11-bit wrap), launchY = playerY, latch slot index, go to LOAD.
    - fireEdge with no free slot: pulse fireDenied and stay in IDLE.
  - LOAD (exactly 1 cycle): loadInitialCoordinates[slot]=1, set slotActive[slot]. Load cooldownCnt=COOLDOWN_FRAMES and go to COOLDOWN.
  - COOLDOWN: decrement cooldownCnt on each startOfFrame. On the startOfFrame where cooldownCnt==1, go to IDLE.
    - fireEdge in COOLDOWN or LOAD: pulse fireDenied; the edge is not queued.
- Slot release: slotActive[i] clears on any cycle where projectileEnd[i]==1 and slotActive[i]==1, except in the LOAD cycle for that same slot. The mover's position is still stale in that cycle, so its projectileEnd is ignored there.
- Simultaneous events:
  - A slot that ends in the same cycle as an IDLE fireEdge is not eligible. Allocation uses the pre-clear vector, so the next free slot is taken, or the shot is denied if none is free.
  - projectileEnd on an inactive slot is ignored.
- readyToFire = (state==IDLE) & |(~slotActive).
- Reset mid-operation: all slots are freed, the FSM goes to IDLE, and in-flight projectiles are abandoned. The movers re-load on their own reset.

## Timing
- Reset values: state=IDLE, slotActive=0, loadInitialCoordinates=0, launchX=0, launchY=0, cooldownCnt=0, fireReg=0, fireDenied=0. readyToFire=1 after reset.
- Edge to strobe: a fireRequest rising edge sampled at edge N gives loadInitialCoordinates high for the cycle after edge N+1. launchX and launchY are valid from edge N+1 and stable throughout the strobe and until the next IDLE latch.
- slotActive[slot] rises on the same edge that ends the strobe.
- Minimum spacing between two strobes is COOLDOWN_FRAMES startOfFrame pulses after LOAD, plus 2 cycles.
- fireDenied is a one-cycle registered pulse, asserted the cycle after the offending edge.
- A startOfFrame coinciding with the LOAD cycle is not counted.

## Test plan
- Single shot: reset, playerX=100, playerY=400, fireRequest rises. Expect loadInitialCoordinates=0001 for exactly 1 cycle, launchX=116, launchY=400, slotActive=0001, readyToFire low until the 8th subsequent startOfFrame.
- Cooldown rejection: fire, then a second edge after 3 frames. Expect fireDenied pulse, no strobe. A third edge after the 8th frame launches slot 1 (strobe 0010).
- Pool exhaustion: NUM_SLOTS=4, fire 4 times past cooldown, then a 5th. Expect fireDenied and slotActive=1111. Pulse projectileEnd[2], fire again: strobe 0100.
- Simultaneous end and fire: slotActive=0111, projectileEnd[0] and fireEdge in the same IDLE cycle. Expect slot 3 loaded and slot 0 cleared, giving slotActive=1110.
- Stale end ignored: hold projectileEnd[0]=1 through the LOAD of slot 0. slotActive[0] stays 1 after LOAD and clears the next cycle.
- Async reset mid-COOLDOWN: assert resetN low with slotActive=0011. Outputs go to reset values immediately, and readyToFire=1 after release.
